// File: rtl/fft_ctrl.sv
// Load/compute sequencer for an in-place radix-2 DIT FFT: one butterfly per cycle.
// Optional FFT_BITREV_EN: bit-reverse the load address so natural-order input gives natural-order output.
module fft_ctrl #(
  parameter int N_LOG2   = 5,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ld_we,
  output logic [N_LOG2-1:0] ld_addr,
  output logic              rd_en,
  output logic [N_LOG2-1:0] rd_addr_a,
  output logic [N_LOG2-1:0] rd_addr_b,
  output logic [N_LOG2-2:0] tw_idx,
  output logic              wr_en,
  output logic [N_LOG2-1:0] wr_addr_a,
  output logic [N_LOG2-1:0] wr_addr_b,
  output logic [2:0]        stage,
  output logic              busy,
  output logic              done
);
  localparam int WCW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, WAIT, DONE} state_t;

  state_t             state, state_n;
  logic [N_LOG2-1:0]  n;
  logic [N_LOG2-2:0]  k;
  logic [2:0]         stage_q;
  logic [WCW-1:0]     wcnt;
  logic               last_w, last_s;

  assign last_w = (wcnt == WCW'(PIPE_LAT-1));
  assign last_s = (stage_q == 3'(N_LOG2-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = LOAD;
      LOAD:    if (ld_we && (&n)) state_n = COMPUTE;
      COMPUTE: if (&k) state_n = WAIT;
      WAIT:    if (last_w) state_n = last_s ? DONE : COMPUTE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign in_ready = (state == LOAD);
  assign ld_we    = in_valid & in_ready;
  assign rd_en    = (state == COMPUTE);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign stage    = stage_q;

  // n and k wrap naturally at the end of load / end of stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n       <= '0;
      k       <= '0;
      stage_q <= '0;
      wcnt    <= '0;
    end else begin
      if (ld_we) n <= n + 1'b1;
      if (state == COMPUTE) k <= k + 1'b1;
      if (state == WAIT) begin
        wcnt <= last_w ? '0 : wcnt + 1'b1;
        if (last_w && !last_s) stage_q <= stage_q + 3'd1;
      end
      if (state == DONE) stage_q <= '0;
    end
  end

`ifdef FFT_BITREV_EN
  always_comb begin
    ld_addr = '0;
    for (int i = 0; i < N_LOG2; i++) ld_addr[i] = n[N_LOG2-1-i];
  end
`else
  assign ld_addr = n;
`endif

  // A = k with a zero inserted at bit position stage; B sets that bit
  logic [N_LOG2-1:0] kx, span, pos, grp, addr_a, tw_full;
  always_comb begin
    kx      = N_LOG2'(k);
    span    = N_LOG2'(1) << stage_q;
    pos     = kx & (span - 1'b1);
    grp     = kx >> stage_q;
    addr_a  = (grp << (stage_q + 3'd1)) | pos;
    tw_full = pos << (3'(N_LOG2-1) - stage_q);
  end

  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? addr_a + span : '0;
  assign tw_idx    = rd_en ? tw_full[N_LOG2-2:0] : '0;

  logic [PIPE_LAT:1]                vld_pipe;
  logic [PIPE_LAT:1][N_LOG2-1:0]    pa_pipe, pb_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      pa_pipe  <= '0;
      pb_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_en;
      pa_pipe[1]  <= rd_addr_a;
      pb_pipe[1]  <= rd_addr_b;
      for (int i = 2; i <= PIPE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        pa_pipe[i]  <= pa_pipe[i-1];
        pb_pipe[i]  <= pb_pipe[i-1];
      end
    end
  end

  assign wr_en     = vld_pipe[PIPE_LAT];
  assign wr_addr_a = pa_pipe[PIPE_LAT];
  assign wr_addr_b = pb_pipe[PIPE_LAT];
endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: cycle-accurate model with a write-back scoreboard queue.
module tb_fft_ctrl;
  logic       clk = 0, reset = 1, start = 0, in_valid = 0;
  logic       in_ready, ld_we, rd_en, wr_en, busy, done;
  logic [4:0] ld_addr, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [3:0] tw_idx;
  logic [2:0] stage;

  int n_checks = 0, n_fail = 0;

  typedef struct { int due; logic [4:0] a; logic [4:0] b; } wexp_t;

  fft_ctrl #(.N_LOG2(5), .PIPE_LAT(2)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_idx(tw_idx),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b),
    .stage(stage), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] brev(input int v);
    logic [4:0] r;
    logic [4:0] x;
    x = v[4:0];
`ifdef FFT_BITREV_EN
    for (int i = 0; i < 5; i++) r[i] = x[4-i];
`else
    r = x;
`endif
    return r;
  endfunction

  // Drives one start+load+compute pass. Returns early (just after the posedge
  // that opens cycle abort_at) when abort_at >= 0.
  task automatic run_pass(input int gap_len, input int start_at, input int abort_at);
    int t_cmp, nm, wr_cnt, rel, s, kk, span, ea, eb, et;
    bit e_rd, e_wr;
    logic [4:0] e_ctrl;
    wexp_t q[$];
    wexp_t w;
    t_cmp = 33 + gap_len; nm = 0; wr_cnt = 0;
    @(posedge clk); #1;
    for (int c = 0; c <= t_cmp + 95; c++) begin
      if (c == abort_at) return;
      start    = (c == 0) || (c == start_at);
      in_valid = !(c >= 10 && c < 10 + gap_len);
      @(negedge clk);
      rel  = c - t_cmp;
      e_rd = (rel >= 0) && (rel < 90) && ((rel % 18) < 16);
      e_ctrl = {(c >= 1 && c <= t_cmp + 90), (c == t_cmp + 90), (c >= 1 && c < t_cmp),
                (c >= 1 && c < t_cmp) && in_valid, e_rd};
      n_checks++;
      if ({busy, done, in_ready, ld_we, rd_en} !== e_ctrl) begin
        n_fail++;
        $display("FAIL ctrl cyc=%0d {busy,done,in_ready,ld_we,rd_en} got %b want %b", c, {busy, done, in_ready, ld_we, rd_en}, e_ctrl);
      end
      n_checks++;
      if (ld_addr !== brev(nm)) begin
        n_fail++;
        $display("FAIL ld_addr cyc=%0d got %0d want %0d", c, ld_addr, brev(nm));
      end
      if (c == 2 || c == 4) begin
        n_checks++;
`ifdef FFT_BITREV_EN
        if (ld_addr !== ((c == 2) ? 5'd16 : 5'd24)) begin
`else
        if (ld_addr !== ((c == 2) ? 5'd1 : 5'd3)) begin
`endif
          n_fail++;
          $display("FAIL ld_addr_spot cyc=%0d got %0d", c, ld_addr);
        end
      end
      if (e_ctrl[1]) nm = (nm + 1) % 32;
      ea = 0; eb = 0; et = 0;
      if (rel >= 0 && rel < 90) begin
        s = rel / 18; kk = rel % 18;
        n_checks++;
        if (stage !== 3'(s)) begin
          n_fail++;
          $display("FAIL stage cyc=%0d got %0d want %0d", c, stage, s);
        end
        if (e_rd) begin
          span = 1 << s;
          ea = kk + (kk & ~(span - 1));
          eb = ea + span;
          et = (kk & (span - 1)) * (16 >> s);
          q.push_back('{due: c + 2, a: 5'(ea), b: 5'(eb)});
          if ((s == 0 && kk == 0) || (s == 2 && kk == 5) || (s == 4 && kk == 15)) begin
            n_checks++;
            if (!((s == 0 && {rd_addr_a, rd_addr_b, tw_idx} === {5'd0, 5'd1, 4'd0}) ||
                  (s == 2 && {rd_addr_a, rd_addr_b, tw_idx} === {5'd9, 5'd13, 4'd4}) ||
                  (s == 4 && {rd_addr_a, rd_addr_b, tw_idx} === {5'd15, 5'd31, 4'd15}))) begin
              n_fail++;
              $display("FAIL addr_spot s=%0d k=%0d got a=%0d b=%0d tw=%0d", s, kk, rd_addr_a, rd_addr_b, tw_idx);
            end
          end
        end
      end
      n_checks++;
      if ({rd_addr_a, rd_addr_b, tw_idx} !== {5'(ea), 5'(eb), 4'(et)}) begin
        n_fail++;
        $display("FAIL rd_addr cyc=%0d got a=%0d b=%0d tw=%0d want a=%0d b=%0d tw=%0d", c, rd_addr_a, rd_addr_b, tw_idx, ea, eb, et);
      end
      e_wr = (q.size() > 0) && (q[0].due == c);
      if (wr_en === 1'b1) wr_cnt++;
      n_checks++;
      if (wr_en !== e_wr) begin
        n_fail++;
        $display("FAIL wr_en cyc=%0d got %b want %b", c, wr_en, e_wr);
      end
      if (e_wr) begin
        w = q.pop_front();
        n_checks++;
        if ({wr_addr_a, wr_addr_b} !== {w.a, w.b}) begin
          n_fail++;
          $display("FAIL wr_addr cyc=%0d got a=%0d b=%0d want a=%0d b=%0d", c, wr_addr_a, wr_addr_b, w.a, w.b);
        end
      end
      @(posedge clk); #1;
    end
    start = 0;
    n_checks++;
    if (wr_cnt != 80 || q.size() != 0) begin
      n_fail++;
      $display("FAIL wr_count got %0d want 80 (pending %0d)", wr_cnt, q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1; start = 0; in_valid = 0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({in_ready, ld_we, rd_en, wr_en, busy, done, ld_addr, rd_addr_a, rd_addr_b, tw_idx, wr_addr_a, wr_addr_b, stage} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals got nonzero output (busy=%b rd_en=%b stage=%0d)", busy, rd_en, stage);
    end
    reset = 0; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready, ld_we, busy} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_in_valid got {in_ready,ld_we,busy}=%b want 000", {in_ready, ld_we, busy});
      end
    end
    in_valid = 0;
  endtask

  task automatic test_full_pass();
    run_pass(0, -1, -1);
  endtask

  task automatic test_gap_and_start();
    run_pass(3, 50, -1);
  endtask

  task automatic test_reset_mid();
    run_pass(0, -1, 76);
    reset = 1;
    #1;
    n_checks++;
    if ({busy, rd_en, wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid got {busy,rd_en,wr_en}=%b want 000", {busy, rd_en, wr_en});
    end
    @(negedge clk);
    reset = 0; start = 0; in_valid = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++;
      if ({busy, wr_en, stage} !== 5'b0) begin
        n_fail++;
        $display("FAIL post_reset cyc=%0d got busy=%b wr_en=%b stage=%0d want 0", i, busy, wr_en, stage);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_pass(0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_full_pass();
    test_gap_and_start();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
